conv_window_rx: RTL
===================

CONV_WINDOW_RX -- requirements
Module: conv_window_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning sample width in bits.
REQ-002 SHALL have parameter TAPS, default 3, meaning window length in samples (legal range 2..16).
REQ-003 SHALL have parameter STRIDE, default 1, meaning new samples between successive windows (legal range 1..TAPS).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, sample strobe; the upstream byte driver is enabled this cycle.
REQ-007 SHALL have port in, input, DATA_W, the sample bus, sampled only when en=1.
REQ-008 SHALL have port clr, input, 1, synchronous restart of window fill; counters and flags are kept.
REQ-009 SHALL have port rd_ready, input, 1, consumer ready for the presented window.
REQ-010 SHALL have port win_valid, output, 1, window presented.
REQ-011 SHALL have port win_data, output, TAPS*DATA_W; slice i is bits [i*DATA_W +: DATA_W]; i=0 is the oldest sample.
REQ-012 SHALL have port win_count, output, 16, number of windows consumed.
REQ-013 SHALL have port overrun, output, 1, sticky flag for a dropped sample.

Function
REQ-014 SHALL accept a sample on a rising edge with en=1, unless held-off per REQ-019.
REQ-015 SHALL shift each accepted sample into slice TAPS-1 (newest), moving every slice down one and discarding slice 0.
REQ-016 SHALL implement states FILL, STEP and HOLD.
- FILL: fill count below TAPS.
- STEP: waiting for STRIDE new samples.
- HOLD: win_valid=1.
REQ-017 SHALL move FILL->HOLD on the accepted sample that makes the fill count equal TAPS, and STEP->HOLD on the accepted sample that makes the stride count equal STRIDE; win_valid rises the next cycle (latency 1 clk).
REQ-018 SHALL complete a handshake on an edge with win_valid=1 and rd_ready=1. On that edge:
- win_count increments, wrapping 0xFFFF->0x0000.
- stride count clears.
- state goes to STEP.
REQ-019 SHALL hold win_data stable in HOLD while rd_ready=0, and discard any en=1 sample in that condition, setting overrun=1.
REQ-020 SHALL, on an edge with win_valid=1, rd_ready=1 and en=1, complete the handshake and accept the sample. If STRIDE=1, the state stays HOLD and win_valid stays 1 with the shifted data, no bubble.
REQ-021 SHALL, on an edge with clr=1, go to FILL, zero fill and stride counts, drop win_valid, ignore en that cycle, and not complete a handshake; win_count and overrun SHALL be unchanged.
REQ-022 SHALL clear overrun only by reset.
REQ-023 SHALL treat clr as dominant over en and rd_ready.
REQ-024 SHALL drive win_data as registers only; it SHALL never be high-impedance.

Reset
REQ-025 SHALL, while rst=0, asynchronously force:
- state FILL and all counts 0;
- win_valid=0, win_data=0, win_count=0, overrun=0.
REQ-026 SHALL resume on the first rising edge after rst returns to 1; a sample with en=1 on that edge is accepted.
REQ-027 SHALL discard a partial or presented window if reset asserts mid-operation, with no handshake counted.

Verification
REQ-028 Fill (TAPS=3, STRIDE=1): en=1 with in=0x11,0x22,0x33 on consecutive edges, rd_ready=1 -> win_valid=1 one clk after 0x33; win_data=0x332211; win_count=1 after the handshake.
REQ-029 Streaming (STRIDE=1): continue with 0x44 while rd_ready=1 -> win_valid stays 1; next win_data=0x443322; no bubble.
REQ-030 Stride (TAPS=3, STRIDE=2): feed 0x01..0x07 with rd_ready=1 -> windows 0x030201, 0x050403, 0x070605; win_count=3.
REQ-031 Backpressure: window presented, rd_ready=0, en=1 with 0x99 -> win_data unchanged, overrun=1 and stays 1; after rd_ready=1, win_count increments once.
REQ-032 clr mid-fill: after 0xAA,0xBB pulse clr, then feed 0x01,0x02,0x03 -> first window 0x030201; overrun unchanged.
REQ-033 Async reset: assert rst=0 mid-clock while win_valid=1 -> win_valid, win_data, win_count and overrun all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/conv_window_rx.sv
// Sliding-window receiver: shifts accepted samples into a TAPS-deep window and
// presents it with a valid/ready handshake every STRIDE new samples.
module conv_window_rx #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 3,
  parameter int STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_W-1:0]        in,
  input  logic                     clr,
  input  logic                     rd_ready,
  output logic                     win_valid,
  output logic [TAPS*DATA_W-1:0]   win_data,
  output logic [15:0]              win_count,
  output logic                     overrun
);

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] TAPS_M1   = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] STRIDE_M1 = CNT_W'(STRIDE - 1);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]             state;
  logic [CNT_W-1:0]       fill_cnt;
  logic [CNT_W-1:0]       stride_cnt;
  logic [TAPS*DATA_W-1:0] shifted;

  // Newest sample enters the top slice; slice 0 (oldest) falls off the bottom.
  assign shifted = {in, win_data[TAPS*DATA_W-1:DATA_W]};

  // NOTE: every register here uses <= so all updates within an edge see the
  // pre-edge values; blocking assignments would make the order of lines matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      fill_cnt   <= '0;
      stride_cnt <= '0;
      win_valid  <= 1'b0;
      win_data   <= '0;
      win_count  <= '0;
      overrun    <= 1'b0;
    end else if (clr) begin
      // Restart the fill only; window contents are overwritten before reuse.
      state      <= FILL;
      fill_cnt   <= '0;
      stride_cnt <= '0;
      win_valid  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (en) begin
            win_data <= shifted;
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == TAPS_M1) begin
              state     <= HOLD;
              win_valid <= 1'b1;
            end
          end
        end
        STEP: begin
          if (en) begin
            win_data   <= shifted;
            stride_cnt <= stride_cnt + 1'b1;
            if (stride_cnt == STRIDE_M1) begin
              state     <= HOLD;
              win_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (rd_ready) begin
            win_count <= win_count + 16'd1;
            if (en) begin
              // Handshake and new sample on the same edge: the sample opens
              // the next stride, which for STRIDE=1 is already complete.
              win_data   <= shifted;
              stride_cnt <= CNT_W'(1);
              if (STRIDE == 1) begin
                state     <= HOLD;
                win_valid <= 1'b1;
              end else begin
                state     <= STEP;
                win_valid <= 1'b0;
              end
            end else begin
              stride_cnt <= '0;
              state      <= STEP;
              win_valid  <= 1'b0;
            end
          end else if (en) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state     <= FILL;
          fill_cnt  <= '0;
          win_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
